// File: rtl/av_pattern_sequencer.sv
// Raster timing, pattern scheduling and audio pacing for the AV test-pattern generator.
// Outputs are registered together with the counters they describe.
module av_pattern_sequencer #(
    parameter int H_ACTIVE           = 640,
    parameter int H_FRONT            = 16,
    parameter int H_SYNC             = 96,
    parameter int H_BACK             = 48,
    parameter int V_ACTIVE           = 480,
    parameter int V_FRONT            = 10,
    parameter int V_SYNC             = 2,
    parameter int V_BACK             = 33,
    parameter bit SYNC_ACTIVE        = 1'b0,
    parameter int NUM_PATTERNS       = 4,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int AUDIO_INC          = 48,
    parameter int AUDIO_MOD          = 25175,
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int PW      = $clog2(NUM_PATTERNS),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          next_pattern,
    input  logic          auto_advance,
    output logic [PW-1:0] pattern_sel,
    output logic [HW-1:0] h_count,
    output logic [VW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          audio_strobe
);

    localparam int FW = $clog2(FRAMES_PER_PATTERN + 1);
    localparam int AW = $clog2(AUDIO_MOD + AUDIO_INC);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW:0]   H_ACT  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   HS_LO  = (HW+1)'(H_ACTIVE + H_FRONT);
    localparam logic [HW:0]   HS_HI  = (HW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW:0]   V_ACT  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   VS_LO  = (VW+1)'(V_ACTIVE + V_FRONT);
    localparam logic [VW:0]   VS_HI  = (VW+1)'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_PATTERNS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_PATTERN - 1);
    localparam logic [AW-1:0] A_INC  = AW'(AUDIO_INC);
    localparam logic [AW-1:0] A_MOD  = AW'(AUDIO_MOD);

    if (AUDIO_INC >= AUDIO_MOD) begin : g_bad_audio
        $error("AUDIO_INC must be smaller than AUDIO_MOD");
    end
    if (NUM_PATTERNS < 2) begin : g_bad_patterns
        $error("NUM_PATTERNS must be at least 2");
    end
    if (FRAMES_PER_PATTERN < 1) begin : g_bad_frames
        $error("FRAMES_PER_PATTERN must be at least 1");
    end

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [PW-1:0] pat_q, pat_d;
    logic [FW-1:0] frm_q, frm_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] acc_sum;
    logic          pend_q, pend_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          act_q, act_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;
    logic          au_q, au_d;
    logic          req;
    logic          adv_auto;

    // Next pixel/line position and the decode of that position.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        act_d = act_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (enable) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
            ls_d  = (h_d == '0);
            fs_d  = (h_d == '0) && (v_d == '0);
            act_d = ({1'b0, h_d} < H_ACT) && ({1'b0, v_d} < V_ACT);
            hs_d  = (({1'b0, h_d} >= HS_LO) && ({1'b0, h_d} < HS_HI))
                    ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_d  = (({1'b0, v_d} >= VS_LO) && ({1'b0, v_d} < VS_HI))
                    ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    // Pattern selection: pending manual request and auto frame counter,
    // both resolved at the frame boundary into at most one advance.
    always_comb begin
        pat_d    = pat_q;
        frm_d    = frm_q;
        pend_d   = pend_q | next_pattern;
        req      = pend_q | next_pattern;
        adv_auto = 1'b0;
        if (enable && !auto_advance) begin
            frm_d = '0;
        end
        if (fs_d) begin
            if (auto_advance) begin
                if (frm_q == F_LAST) begin
                    adv_auto = 1'b1;
                end else begin
                    frm_d = frm_q + 1'b1;
                end
            end
            if (req || adv_auto) begin
                pat_d = (pat_q == P_LAST) ? '0 : pat_q + 1'b1;
                frm_d = '0;
            end
            pend_d = 1'b0;
        end
    end

    // Fractional-rate audio strobe from a modulo accumulator.
    always_comb begin
        acc_sum = acc_q + A_INC;
        acc_d   = acc_q;
        au_d    = 1'b0;
        if (enable) begin
            if (acc_sum >= A_MOD) begin
                acc_d = acc_sum - A_MOD;
                au_d  = 1'b1;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q    <= '0;
            v_q    <= '0;
            pat_q  <= '0;
            frm_q  <= '0;
            acc_q  <= '0;
            pend_q <= 1'b0;
            hs_q   <= ~SYNC_ACTIVE;
            vs_q   <= ~SYNC_ACTIVE;
            act_q  <= 1'b1;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            au_q   <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            pat_q  <= pat_d;
            frm_q  <= frm_d;
            acc_q  <= acc_d;
            pend_q <= pend_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            act_q  <= act_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            au_q   <= au_d;
        end
    end

    assign pattern_sel  = pat_q;
    assign h_count      = h_q;
    assign v_count      = v_q;
    assign hsync        = hs_q;
    assign vsync        = vs_q;
    assign active       = act_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign audio_strobe = au_q;

endmodule

// File: tb/tb_av_pattern_sequencer.sv
// Directed bench for av_pattern_sequencer on a tiny 8x6 raster.
// Vectors carry per-cycle inputs and hand-computed outputs.
module tb_av_pattern_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       next_pattern = 1'b0;
    logic       auto_advance = 1'b0;
    logic [1:0] pattern_sel;
    logic [2:0] h_count;
    logic [2:0] v_count;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic       audio_strobe;

    int n_cmp = 0;
    int n_bad = 0;

    av_pattern_sequencer #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE(1'b0), .NUM_PATTERNS(3), .FRAMES_PER_PATTERN(2),
        .AUDIO_INC(3), .AUDIO_MOD(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .next_pattern(next_pattern),
        .auto_advance(auto_advance),
        .pattern_sel(pattern_sel),
        .h_count(h_count),
        .v_count(v_count),
        .hsync(hsync),
        .vsync(vsync),
        .active(active),
        .line_start(line_start),
        .frame_start(frame_start),
        .audio_strobe(audio_strobe)
    );

    always #5 clock = ~clock;

    // cyc: cycle after reset release; en/np: inputs sampled at that edge;
    // full = 0 compares pattern_sel only.
    typedef struct {
        int          cyc;
        bit          en;
        bit          np;
        bit          full;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] pk(int pat, int h, int v, bit hs, bit vs,
                                       bit act, bit ls, bit fs, bit au);
        return {2'(pat), 3'(h), 3'(v), hs, vs, act, ls, fs, au};
    endfunction

    function automatic logic [13:0] obs();
        return {pattern_sel, h_count, v_count, hsync, vsync,
                active, line_start, frame_start, audio_strobe};
    endfunction

    task automatic add(int cyc, bit en, bit np, int pat, int h, int v,
                       bit hs, bit vs, bit act, bit ls, bit fs, bit au);
        vec_t r;
        r.cyc  = cyc;
        r.en   = en;
        r.np   = np;
        r.full = 1'b1;
        r.exp  = pk(pat, h, v, hs, vs, act, ls, fs, au);
        vecs.push_back(r);
    endtask

    task automatic addp(int cyc, bit np, int pat);
        vec_t r;
        r.cyc  = cyc;
        r.en   = 1'b1;
        r.np   = np;
        r.full = 1'b0;
        r.exp  = {2'(pat), 12'b0};
        vecs.push_back(r);
    endtask

    task automatic check(string name, logic [13:0] got, logic [13:0] need, bit full);
        bit bad;
        n_cmp++;
        if (full) bad = (got !== need);
        else      bad = (got[13:12] !== need[13:12]);
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got pat=%0d h=%0d v=%0d hs,vs,act,ls,fs,au=%b need pat=%0d h=%0d v=%0d hs,vs,act,ls,fs,au=%b",
                     name, got[13:12], got[11:9], got[8:6], got[5:0],
                     need[13:12], need[11:9], need[8:6], need[5:0]);
        end
    endtask

    task automatic do_reset(bit aa);
        vecs.delete();
        reset_n      = 1'b0;
        enable       = 1'b1;
        next_pattern = 1'b0;
        auto_advance = aa;
        repeat (2) @(posedge clock);
        #1;
        check("reset", obs(), pk(0, 0, 0, 1, 1, 1, 0, 0, 0), 1'b1);
        reset_n = 1'b1;
    endtask

    task automatic run(string name, int last);
        int k;
        bit hit;
        k = 0;
        for (int n = 1; n <= last; n++) begin
            hit = (k < vecs.size()) && (vecs[k].cyc == n);
            enable       = hit ? vecs[k].en : 1'b1;
            next_pattern = hit ? vecs[k].np : 1'b0;
            @(posedge clock);
            #1;
            if (hit) begin
                check($sformatf("%s@%0d", name, n), obs(), vecs[k].exp, vecs[k].full);
                k++;
            end
        end
        enable       = 1'b1;
        next_pattern = 1'b0;
    endtask

    initial begin
        // Raster, strobes, audio and manual requests collapsing to one advance.
        do_reset(1'b0);
        add( 3, 1, 0, 0, 3, 0, 1, 1, 1, 0, 0, 1);
        add( 5, 1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
        add( 6, 1, 0, 0, 6, 0, 0, 1, 0, 0, 0, 1);
        add( 7, 1, 0, 0, 7, 0, 1, 1, 0, 0, 0, 0);
        add( 8, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1);
        add(10, 1, 1, 0, 2, 1, 1, 1, 1, 0, 0, 0);
        add(20, 1, 1, 0, 4, 2, 1, 1, 0, 0, 0, 0);
        add(24, 1, 0, 0, 0, 3, 1, 1, 0, 1, 0, 1);
        add(32, 1, 0, 0, 0, 4, 1, 0, 0, 1, 0, 1);
        add(37, 1, 0, 0, 5, 4, 0, 0, 0, 0, 0, 0);
        add(40, 1, 0, 0, 0, 5, 1, 1, 0, 1, 0, 1);
        add(47, 1, 0, 0, 7, 5, 1, 1, 0, 0, 0, 0);
        add(48, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1);
        add(49, 1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0);
        add(96, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1);
        run("raster", 96);

        // Auto mode with a manual request landing on an auto advance.
        do_reset(1'b1);
        addp( 95, 0, 0);
        addp( 96, 0, 1);
        addp(150, 1, 1);
        addp(191, 0, 1);
        addp(192, 0, 2);
        addp(240, 0, 2);
        addp(287, 0, 2);
        addp(288, 0, 0);
        run("auto", 288);

        // Manual advance restarts the auto frame count.
        do_reset(1'b1);
        addp( 96, 0, 1);
        addp(100, 1, 1);
        addp(143, 0, 1);
        addp(144, 0, 2);
        addp(192, 0, 2);
        addp(239, 0, 2);
        addp(240, 0, 0);
        run("auto_man", 240);

        // Freeze for 5 cycles with a request captured during the freeze.
        do_reset(1'b0);
        add( 8, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1);
        for (int c = 9; c <= 13; c++) begin
            add(c, 0, (c == 11), 0, 0, 1, 1, 1, 1, 0, 0, 0);
        end
        add(14, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0);
        add(16, 1, 0, 0, 3, 1, 1, 1, 1, 0, 0, 1);
        add(52, 1, 0, 0, 7, 5, 1, 1, 0, 0, 0, 0);
        add(53, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1);
        run("freeze", 53);

        // Asynchronous reset mid-frame discards the pending request.
        do_reset(1'b0);
        addp(10, 1, 0);
        add(27, 1, 0, 0, 3, 3, 1, 1, 0, 0, 0, 1);
        run("pre_rst", 27);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst", obs(), pk(0, 0, 0, 1, 1, 1, 0, 0, 0), 1'b1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        vecs.delete();
        add( 1, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        add( 5, 1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
        add( 6, 1, 0, 0, 6, 0, 0, 1, 0, 0, 0, 1);
        add(48, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1);
        run("post_rst", 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/av_pattern_sequencer.md
Name: av_pattern_sequencer

Overview:
- Timing and scheduling controller for the AV test-pattern generator.
- Produces raster timing: pixel/line counters, syncs, active video, and frame/line strobes.
- Selects which test pattern the pattern datapath renders, switching only at frame boundaries, on request or automatically every N frames.
- Generates a fractional-rate audio sample strobe that paces the test-tone datapath.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync
NUM_PATTERNS, 4, number of patterns (>=2); PW = clog2(NUM_PATTERNS)
FRAMES_PER_PATTERN, 120, frames per pattern in auto mode (>=1)
AUDIO_INC, 48, audio accumulator increment per clock
AUDIO_MOD, 25175, accumulator modulus; AUDIO_INC < AUDIO_MOD (elaboration error otherwise)

Ports:
clock  in  1  system/pixel clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run/freeze for all counters and accumulators
next_pattern  in  1  synchronous request to advance the pattern; level sampled each cycle
auto_advance  in  1  1 = advance every FRAMES_PER_PATTERN frames
pattern_sel  out  PW  current pattern index
h_count  out  clog2(H_TOTAL)  pixel counter, H_TOTAL = sum of H_* parameters
v_count  out  clog2(V_TOTAL)  line counter, V_TOTAL = sum of V_* parameters
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active  out  1  visible pixel
line_start  out  1  one-cycle pulse at h_count == 0
frame_start  out  1  one-cycle pulse at h_count == 0 and v_count == 0
audio_strobe  out  1  one-cycle audio sample pulse

Behaviour:
- Reset values:
  - Counters: h_count = 0, v_count = 0, pattern_sel = 0.
  - Internal state: frame counter = 0, pending request = 0, accumulator = 0.
  - active = 1 (pixel 0,0 is visible); hsync/vsync = !SYNC_ACTIVE; all strobes = 0.
- Output registering:
  - Every output is registered and consistent with the h_count/v_count presented in the same cycle.
  - Decode latency is 0 relative to the counters.
- Counters, each cycle with enable = 1:
  - h_count increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_count increments and wraps V_TOTAL-1 -> 0.
- Decode:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync = SYNC_ACTIVE when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync = SYNC_ACTIVE for whole lines where V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC.
- Strobes:
  - line_start and frame_start assert only in the cycle a wrap lands on h = 0 (resp. h = 0, v = 0).
  - Neither asserts in the reset state.
- enable = 0:
  - All counters, the accumulator, pattern_sel and the frame counter hold.
  - Strobes = 0; active/hsync/vsync hold their last values.
  - next_pattern is still captured into the pending request.
- Pattern scheduling:
  - next_pattern = 1 in any cycle sets the pending request.
  - The request takes effect at the next frame_start: pattern_sel advances by one in the same cycle frame_start is presented.
  - Pending and frame counter clear at that point.
  - A request sampled in the cycle immediately before frame_start is applied at that frame_start.
  - Multiple requests within one frame produce a single advance.
- Auto mode:
  - Frame counter increments at each frame_start while auto_advance = 1.
  - At the frame_start where it would reach FRAMES_PER_PATTERN, pattern_sel advances and the counter returns to 0.
  - auto_advance = 0 forces the frame counter to 0.
  - Manual and auto advance coinciding at the same frame_start: advance by exactly one.
- Wrap: pattern_sel wraps NUM_PATTERNS-1 -> 0; it never takes a value >= NUM_PATTERNS.
- Audio, each enabled cycle:
  - If acc + AUDIO_INC >= AUDIO_MOD: acc <= acc + AUDIO_INC - AUDIO_MOD and audio_strobe <= 1.
  - Otherwise acc <= acc + AUDIO_INC and audio_strobe <= 0.
  - The accumulator is wide enough for AUDIO_MOD + AUDIO_INC without overflow.
- Reset mid-frame: immediate return to reset values; a pending request is discarded.

Test Plan:
Bench parameters: H = 4/1/2/1 (H_TOTAL 8), V = 3/1/1/1 (V_TOTAL 6), NUM_PATTERNS 3, FRAMES_PER_PATTERN 2, AUDIO_INC 3, AUDIO_MOD 8.
1. Release reset, enable = 1 -> h_count sequence 0..7 repeating. hsync = 0 exactly at h = 5,6. active only for h < 4 and v < 3. vsync = 0 for all of line 4. First frame_start at cycle 48; line_start every 8 cycles starting at cycle 8.
2. Pulse next_pattern at cycle 10 and cycle 20 -> pattern_sel 0 -> 1 at cycle 48 only; no change at cycle 96.
3. auto_advance = 1 from reset -> pattern_sel = 1 at cycle 96, 2 at 192, 0 at 288 (wrap). Manual pulse at cycle 100 -> advance at 144; the next auto advance follows 2 frames later, at 240.
4. Audio: 8 enabled cycles after reset -> audio_strobe at cycles 3, 6 and 8 (acc 3,6,1,4,7,2,5,0), i.e. 3 strobes per 8 cycles.
5. Drop enable for 5 cycles mid-line -> counters, acc and pattern_sel frozen; strobes 0; a next_pattern pulse during the freeze is applied at the following frame_start.
6. Assert reset_n low mid-frame with a request pending -> all outputs return to reset values asynchronously; after release no pattern advance occurs at the first frame_start.
